priority_route_demux: RTL and testbench
=======================================

Name: priority_route_demux

Overview:
- Inverse of the registered priority select used in the timing exercises: one 8-bit valid/ready input stream is routed to one of three output channels (A, B, C) using the same priority rule.
- Each channel has a small FIFO so that backpressure on one consumer does not immediately stall the others.
- Sits between a single producer and three independent consumers. All outputs are registered; no combinational input-to-output path.

Parameters:
- DATA_W, 8, width of the data path.
- DEPTH, 2, entries per channel FIFO; must be a power of 2 and at least 2.
- THRESH, 8, unsigned compare constant for the B-route rule (data < THRESH).

Ports:
- i_clk  in  1  clock.
- i_arst  in  1  reset, asynchronous, active-high.
- i_valid  in  1  input beat valid.
- o_ready  out  1  input can accept a beat.
- i_data  in  DATA_W  input data.
- i_cond1  in  1  route-to-A condition, sampled with the beat.
- i_cond2  in  1  route-to-B qualifier, sampled with the beat.
- o_a_valid / i_a_ready / o_a_data  out/in/out  1/1/DATA_W  channel A stream.
- o_b_valid / i_b_ready / o_b_data  out/in/out  1/1/DATA_W  channel B stream.
- o_c_valid / i_c_ready / o_c_data  out/in/out  1/1/DATA_W  channel C stream.

Behaviour:
- Accept: a beat transfers when i_valid && o_ready at a rising edge of i_clk.
- Routing is evaluated on the accepted beat. Priority is highest first:
  - i_cond1 → A.
  - else i_cond2 && (i_data < THRESH), unsigned compare → B.
  - else → C.
- Exactly one channel receives each beat; beats are never duplicated or dropped.
- o_ready = 1 only when every channel FIFO has count < DEPTH.
  - It is derived from registered counts only: no dependence on i_data, i_cond*, or i_*_ready.
  - A same-cycle pop does not free a slot for that cycle.
- Latency: an accepted beat appears on its channel output at the next edge; minimum 1 cycle, input to o_x_valid.
- Output valid/data:
  - o_x_valid = channel count != 0.
  - o_x_data = FIFO head, held stable while o_x_valid && !i_x_ready.
- Per-channel FIFO:
  - Read/write pointers of log2(DEPTH) bits wrap naturally modulo DEPTH.
  - Count is log2(DEPTH)+1 bits.
  - Push only, pop only, or push+pop in the same cycle: count +1, −1, or unchanged respectively.
  - Push+pop on an empty FIFO is impossible because valid=0.
  - Each channel preserves order; no ordering is guaranteed between channels.
- Reset (i_arst high, at any time including mid-transfer):
  - All pointers and counts go to 0 immediately.
  - o_a/b/c_valid = 0; o_ready = 0 while reset is asserted, 1 from the first cycle after deassertion.
  - Data registers reset to 0.
  - In-flight beats are discarded.
- i_cond1, i_cond2 and i_data are ignored when i_valid = 0 or o_ready = 0.

Optional Feature:
- Macro PRIORITY_ROUTE_STATS_EN.
- With it, the block adds outputs o_cnt_a, o_cnt_b, o_cnt_c (16 bits each): registered counts of beats accepted per channel.
  - Each counter increments on the edge where a beat is routed to that channel.
  - Counters saturate at 16'hFFFF and reset to 0 on i_arst.
- Without it, these ports and their logic do not exist; all other behaviour is identical.

Decomposition:
- Package priority_route_pkg:
  - Enum route_e {ROUTE_A, ROUTE_B, ROUTE_C}.
  - Default parameter constants.
  - Pure function route_sel(cond1, cond2, data) returning route_e, shared with the testbench scoreboard.
- Sub-module route_fifo (DATA_W, DEPTH): push/pop, registered count, head data, full/empty.
  - Instantiated three times.

Test Plan:
- Priority: beats (cond1=1,cond2=1,data=8'h03), (0,1,8'h03), (0,1,8'h08), (0,0,8'h01), all consumers ready → A gets 8'h03, B gets 8'h03, C gets 8'h08 then 8'h01; each appears 1 cycle after acceptance.
- Boundary compare: cond2=1 with data 8'h07 → B; data 8'h08 → C; data 8'hFF → C.
- Backpressure/full: i_a_ready=0, send 2 A-beats (DEPTH=2) → o_ready drops to 0 the cycle after the 2nd accept; a C-beat waiting on i_valid is not accepted. Release i_a_ready → A drains 2 beats in order and o_ready returns to 1.
- Simultaneous push/pop: A count=1, i_a_ready=1, push A-beat the same cycle → count stays 1, data order preserved; wrap over 10 beats with no loss.
- Reset mid-operation: with A holding 2 entries and B holding 1, assert i_arst for 1 cycle → all o_x_valid=0 asynchronously and o_ready=0; after release, o_ready=1 and no stale data emerges.
- With PRIORITY_ROUTE_STATS_EN: 5 A, 3 B and 7 C beats → o_cnt_a=5, o_cnt_b=3, o_cnt_c=7; force o_cnt_c to 16'hFFFE, send 3 C-beats → o_cnt_c holds at 16'hFFFF.

Source files
------------

// File: rtl/priority_route_pkg.sv
// Shared types, default constants and the routing rule for priority_route_demux.
package priority_route_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned DEPTH_DEF  = 2;
  localparam int unsigned THRESH_DEF = 8;

  typedef enum logic [1:0] {
    ROUTE_A = 2'd0,
    ROUTE_B = 2'd1,
    ROUTE_C = 2'd2
  } route_e;

  // cond1 wins; otherwise cond2 with data below thresh goes to B; everything else to C
  function automatic route_e route_sel(input logic        cond1,
                                       input logic        cond2,
                                       input logic [31:0] data,
                                       input int unsigned thresh = THRESH_DEF);
    route_e r;
    if (cond1)                        r = ROUTE_A;
    else if (cond2 && (data < thresh)) r = ROUTE_B;
    else                              r = ROUTE_C;
    return r;
  endfunction

endpackage

// File: rtl/priority_route_demux_if.sv
// Producer/consumer stream bundle for priority_route_demux.
// Stats counters exist only when PRIORITY_ROUTE_STATS_EN is defined.
interface priority_route_demux_if #(
  parameter int unsigned DATA_W = priority_route_pkg::DATA_W_DEF
);
  logic              i_valid;
  logic              o_ready;
  logic [DATA_W-1:0] i_data;
  logic              i_cond1;
  logic              i_cond2;
  logic              o_a_valid;
  logic              i_a_ready;
  logic [DATA_W-1:0] o_a_data;
  logic              o_b_valid;
  logic              i_b_ready;
  logic [DATA_W-1:0] o_b_data;
  logic              o_c_valid;
  logic              i_c_ready;
  logic [DATA_W-1:0] o_c_data;
`ifdef PRIORITY_ROUTE_STATS_EN
  logic [15:0]       o_cnt_a;
  logic [15:0]       o_cnt_b;
  logic [15:0]       o_cnt_c;
`endif

  modport master (
    output i_valid, i_data, i_cond1, i_cond2, i_a_ready, i_b_ready, i_c_ready,
    input  o_ready, o_a_valid, o_a_data, o_b_valid, o_b_data, o_c_valid, o_c_data
`ifdef PRIORITY_ROUTE_STATS_EN
    , input o_cnt_a, o_cnt_b, o_cnt_c
`endif
  );

  modport slave (
    input  i_valid, i_data, i_cond1, i_cond2, i_a_ready, i_b_ready, i_c_ready,
    output o_ready, o_a_valid, o_a_data, o_b_valid, o_b_data, o_c_valid, o_c_data
`ifdef PRIORITY_ROUTE_STATS_EN
    , output o_cnt_a, o_cnt_b, o_cnt_c
`endif
  );

endinterface

// File: rtl/route_fifo.sv
// Per-channel FIFO: registered pointers/count, head read straight from storage.
module route_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic              full_c,
  output logic              empty_c
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              do_push, do_pop;

  assign full_c  = (count_q == CW'(DEPTH));
  assign empty_c = (count_q == '0);
  assign do_push = push_i & ~full_c;
  assign do_pop  = pop_i & ~empty_c;
  assign data_o  = mem_q[rptr_q];

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) begin
      mem_d[wptr_q] = data_i;
      wptr_d        = wptr_q + PW'(1);
    end
    if (do_pop) rptr_d = rptr_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q   <= '{default: '0};
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/priority_route_demux.sv
// Routes one valid/ready stream to channels A/B/C by priority, one FIFO per channel.
// Optional per-channel accept counters under PRIORITY_ROUTE_STATS_EN.
module priority_route_demux
  import priority_route_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned THRESH = THRESH_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_arst,
  priority_route_demux_if.slave bus
);
  route_e            route_c;
  logic              accept_c;
  logic              ready_en_q;
  logic [2:0]        push, pop, full, empty, rdy_in;
  logic [DATA_W-1:0] head [3];

  assign route_c  = route_sel(bus.i_cond1, bus.i_cond2, 32'(bus.i_data), THRESH);
  assign accept_c = bus.i_valid & bus.o_ready;
  assign push     = {accept_c && (route_c == ROUTE_C),
                     accept_c && (route_c == ROUTE_B),
                     accept_c && (route_c == ROUTE_A)};
  assign rdy_in   = {bus.i_c_ready, bus.i_b_ready, bus.i_a_ready};
  assign pop      = rdy_in & ~empty;

  // Holds ready low through reset; full flags come only from registered counts
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) ready_en_q <= 1'b0;
    else        ready_en_q <= 1'b1;
  end
  assign bus.o_ready = ready_en_q & ~(|full);

  for (genvar g = 0; g < 3; g++) begin : g_ch
    route_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk    (i_clk),
      .rst    (i_arst),
      .push_i (push[g]),
      .data_i (bus.i_data),
      .pop_i  (pop[g]),
      .data_o (head[g]),
      .full_c (full[g]),
      .empty_c(empty[g])
    );
  end

  assign bus.o_a_valid = ~empty[0];
  assign bus.o_b_valid = ~empty[1];
  assign bus.o_c_valid = ~empty[2];
  assign bus.o_a_data  = head[0];
  assign bus.o_b_data  = head[1];
  assign bus.o_c_data  = head[2];

`ifdef PRIORITY_ROUTE_STATS_EN
  logic [15:0] cnt_q [3];
  logic [15:0] cnt_d [3];

  // Saturating count of beats routed to each channel
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < 3; i++) begin
      if (push[i] && (cnt_q[i] != 16'hFFFF)) cnt_d[i] = cnt_q[i] + 16'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) cnt_q <= '{default: '0};
    else        cnt_q <= cnt_d;
  end

  assign bus.o_cnt_a = cnt_q[0];
  assign bus.o_cnt_b = cnt_q[1];
  assign bus.o_cnt_c = cnt_q[2];
`endif

endmodule

// File: tb/tb_priority_route_demux.sv
// Self-checking bench for priority_route_demux with a queue-based reference model.
module tb_priority_route_demux;
  import priority_route_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  priority_route_demux_if #(.DATA_W(8)) bus ();

  priority_route_demux dut (
    .i_clk (clk),
    .i_arst(rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] q [3][$];
  bit         en_m;

  function automatic int ref_route(logic c1, logic c2, logic [7:0] d);
    if (c1) return 0;
    if (c2 && (d < 8'd8)) return 1;
    return 2;
  endfunction

  function automatic bit model_ready();
    return en_m && (q[0].size() < 2) && (q[1].size() < 2) && (q[2].size() < 2);
  endfunction

  function automatic logic dut_valid(int c);
    case (c)
      0:       return bus.o_a_valid;
      1:       return bus.o_b_valid;
      default: return bus.o_c_valid;
    endcase
  endfunction

  function automatic logic [7:0] dut_data(int c);
    case (c)
      0:       return bus.o_a_data;
      1:       return bus.o_b_data;
      default: return bus.o_c_data;
    endcase
  endfunction

  function automatic logic ready_in(int c);
    case (c)
      0:       return bus.i_a_ready;
      1:       return bus.i_b_ready;
      default: return bus.i_c_ready;
    endcase
  endfunction

  task automatic set_ready(input logic a, input logic b, input logic c);
    bus.i_a_ready = a;
    bus.i_b_ready = b;
    bus.i_c_ready = c;
  endtask

  task automatic drive(input logic v, input logic c1, input logic c2, input logic [7:0] d);
    bus.i_valid = v;
    bus.i_cond1 = c1;
    bus.i_cond2 = c2;
    bus.i_data  = d;
  endtask

  // Advance one clock: apply pops and the accepted beat to the model, then sample at negedge
  task automatic cycle();
    bit r;
    r = model_ready();
    for (int c = 0; c < 3; c++)
      if ((q[c].size() > 0) && ready_in(c)) void'(q[c].pop_front());
    if (bus.i_valid && r) q[ref_route(bus.i_cond1, bus.i_cond2, bus.i_data)].push_back(bus.i_data);
    @(posedge clk);
    if (!rst) en_m = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en_m = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    set_ready(1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    checks++;
    if (bus.o_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %0b want 0", bus.o_ready); end
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (dut_valid(c) !== 1'b0) begin errors++; $display("FAIL reset_valid ch%0d got %0b want 0", c, dut_valid(c)); end
      checks++;
      if (dut_data(c) !== 8'h00) begin errors++; $display("FAIL reset_data ch%0d got %0h want 00", c, dut_data(c)); end
    end
    rst = 1'b0;
    cycle();
    checks++;
    if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got %0b want 1", bus.o_ready); end
  endtask

  task automatic test_priority();
    logic [7:0] td [4] = '{8'h03, 8'h03, 8'h08, 8'h01};
    logic       t1 [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic       t2 [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    int         ech [4] = '{0, 1, 2, 2};
    set_ready(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, t1[i], t2[i], td[i]);
      cycle();
      for (int c = 0; c < 3; c++) begin
        checks++;
        if (dut_valid(c) !== (c == ech[i])) begin
          errors++; $display("FAIL prio_valid beat%0d ch%0d got %0b want %0b", i, c, dut_valid(c), (c == ech[i]));
        end
      end
      checks++;
      if (dut_data(ech[i]) !== td[i]) begin
        errors++; $display("FAIL prio_data beat%0d got %0h want %0h", i, dut_data(ech[i]), td[i]);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    cycle();
  endtask

  task automatic test_boundary();
    logic [7:0] td [6] = '{8'h07, 8'h08, 8'hFF, 8'h00, 8'hFF, 8'h00};
    logic       t1 [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       t2 [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    int         ech [6] = '{1, 2, 2, 2, 0, 1};
    set_ready(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, t1[i], t2[i], td[i]);
      cycle();
      drive(1'b0, 1'b0, 1'b0, 8'h00);
      checks++;
      if (dut_valid(ech[i]) !== 1'b1 || dut_data(ech[i]) !== td[i]) begin
        errors++; $display("FAIL boundary beat%0d ch%0d got v=%0b d=%0h want v=1 d=%0h",
                           i, ech[i], dut_valid(ech[i]), dut_data(ech[i]), td[i]);
      end
      cycle();
    end
  endtask

  task automatic test_backpressure();
    set_ready(1'b0, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 8'hA1);
    cycle();
    checks++;
    if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_one got %0b want 1", bus.o_ready); end
    drive(1'b1, 1'b1, 1'b0, 8'hA2);
    cycle();
    checks++;
    if (bus.o_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full got %0b want 0", bus.o_ready); end
    drive(1'b1, 1'b0, 1'b0, 8'hC1);
    cycle();
    cycle();
    checks++;
    if (bus.o_c_valid !== 1'b0 || bus.o_a_data !== 8'hA1) begin
      errors++; $display("FAIL bp_stall got c_valid=%0b a_data=%0h want 0 A1", bus.o_c_valid, bus.o_a_data);
    end
    set_ready(1'b1, 1'b1, 1'b1);
    cycle();
    checks++;
    if (bus.o_ready !== 1'b1 || bus.o_a_data !== 8'hA2 || bus.o_c_valid !== 1'b0) begin
      errors++; $display("FAIL bp_drain1 got ready=%0b a_data=%0h c_valid=%0b want 1 A2 0",
                         bus.o_ready, bus.o_a_data, bus.o_c_valid);
    end
    cycle();
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    checks++;
    if (bus.o_a_valid !== 1'b0 || bus.o_c_valid !== 1'b1 || bus.o_c_data !== 8'hC1) begin
      errors++; $display("FAIL bp_drain2 got a_valid=%0b c_valid=%0b c_data=%0h want 0 1 C1",
                         bus.o_a_valid, bus.o_c_valid, bus.o_c_data);
    end
    cycle();
  endtask

  task automatic test_push_pop();
    set_ready(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 8'h10);
    cycle();
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, 1'b1, 1'b0, 8'(8'h10 + i));
      cycle();
      checks++;
      if (bus.o_a_valid !== 1'b1 || bus.o_a_data !== 8'(8'h10 + i) || bus.o_ready !== 1'b1) begin
        errors++; $display("FAIL pushpop step%0d got v=%0b d=%0h rdy=%0b want 1 %0h 1",
                           i, bus.o_a_valid, bus.o_a_data, bus.o_ready, 8'(8'h10 + i));
      end
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    cycle();
    checks++;
    if (bus.o_a_valid !== 1'b0) begin errors++; $display("FAIL pushpop_empty got %0b want 0", bus.o_a_valid); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 15)) : 8'($urandom));
      set_ready(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 7));
      cycle();
      checks++;
      if (bus.o_ready !== model_ready()) begin
        errors++; $display("FAIL rand_ready n=%0d got %0b want %0b", n, bus.o_ready, model_ready());
      end
      for (int c = 0; c < 3; c++) begin
        checks++;
        if (dut_valid(c) !== (q[c].size() != 0)) begin
          errors++; $display("FAIL rand_valid n=%0d ch%0d got %0b want %0b", n, c, dut_valid(c), (q[c].size() != 0));
        end else if (q[c].size() != 0 && dut_data(c) !== q[c][0]) begin
          errors++; $display("FAIL rand_data n=%0d ch%0d got %0h want %0h", n, c, dut_data(c), q[c][0]);
        end
      end
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    set_ready(1'b1, 1'b1, 1'b1);
    repeat (3) cycle();
  endtask

  task automatic test_reset_mid();
    set_ready(1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 8'h05);
    cycle();
    drive(1'b1, 1'b1, 1'b0, 8'h55);
    cycle();
    drive(1'b1, 1'b1, 1'b0, 8'h66);
    cycle();
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    checks++;
    if (bus.o_ready !== 1'b0 || bus.o_a_valid !== 1'b1 || bus.o_b_valid !== 1'b1) begin
      errors++; $display("FAIL mid_fill got rdy=%0b a=%0b b=%0b want 0 1 1", bus.o_ready, bus.o_a_valid, bus.o_b_valid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.o_a_valid !== 1'b0 || bus.o_b_valid !== 1'b0 || bus.o_c_valid !== 1'b0 || bus.o_ready !== 1'b0) begin
      errors++; $display("FAIL mid_async got a=%0b b=%0b c=%0b rdy=%0b want 0 0 0 0",
                         bus.o_a_valid, bus.o_b_valid, bus.o_c_valid, bus.o_ready);
    end
    for (int c = 0; c < 3; c++) q[c].delete();
    en_m = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    set_ready(1'b1, 1'b1, 1'b1);
    cycle();
    checks++;
    if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL mid_release_ready got %0b want 1", bus.o_ready); end
    for (int n = 0; n < 3; n++) begin
      for (int c = 0; c < 3; c++) begin
        checks++;
        if (dut_valid(c) !== 1'b0) begin errors++; $display("FAIL mid_stale n=%0d ch%0d got %0b want 0", n, c, dut_valid(c)); end
      end
      cycle();
    end
  endtask

`ifdef PRIORITY_ROUTE_STATS_EN
  task automatic test_stats();
    int na, nb, nc;
    na = 0; nb = 0; nc = 0;
    set_ready(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 15; i++) begin
      if (i < 5) begin drive(1'b1, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom)); na++; end
      else if (i < 8) begin drive(1'b1, 1'b0, 1'b1, 8'($urandom_range(0, 7))); nb++; end
      else begin drive(1'b1, 1'b0, 1'b0, 8'($urandom)); nc++; end
      cycle();
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    cycle();
    checks++;
    if (bus.o_cnt_a !== 16'(na) || bus.o_cnt_b !== 16'(nb) || bus.o_cnt_c !== 16'(nc)) begin
      errors++; $display("FAIL stats_counts got %0d %0d %0d want %0d %0d %0d",
                         bus.o_cnt_a, bus.o_cnt_b, bus.o_cnt_c, na, nb, nc);
    end
    dut.cnt_q[2] = 16'hFFFE;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, 8'h20);
      cycle();
      checks++;
      if (bus.o_cnt_c !== 16'hFFFF) begin errors++; $display("FAIL stats_sat i=%0d got %0h want ffff", i, bus.o_cnt_c); end
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    cycle();
  endtask
`endif

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_priority();
    test_boundary();
    test_backpressure();
    test_push_pop();
    test_random();
    test_reset_mid();
`ifdef PRIORITY_ROUTE_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
